// File: rtl/dcache_config.sv
// Shared cache-side AXI constants and the refill read-channel state encoding.
package dcache_config;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic [3:0] AR_CACHE    = 4'b0011;
    localparam logic [2:0] AR_PROT     = 3'b000;
    localparam logic [3:0] AR_QOS      = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } rd_state_t;

endpackage

// File: rtl/refill_read_channel_if.sv
// AXI4 read-address / read-data channel bundle between refill master and slave.
interface refill_read_channel_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 4
);
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [AXI_ID_W-1:0] arid;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arqos, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arqos, arid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/refill_read_channel.sv
// AXI4 read master for cache line refills and uncached loads, with
// critical-word-first WRAP bursts, burst-length checking and bounded retry.
module refill_read_channel
    import dcache_config::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LINE_BEATS_W = 2,
    parameter int AXI_ID_W     = 4,
    parameter int AXI_ID       = 0,
    parameter int MAX_RETRY    = 3,
    parameter bit WRAP_EN      = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    req_uncached,
    output logic                    busy,
    output logic                    beat_valid,
    output logic [LINE_BEATS_W-1:0] beat_idx,
    output logic [DATA_W-1:0]       beat_data,
    output logic                    beat_last,
    output logic                    done,
    output logic                    error,
    refill_read_channel_if.master   axi
);

    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int BEATS  = 1 << LINE_BEATS_W;
    localparam int CNT_W  = LINE_BEATS_W + 1;
    localparam int RW     = $clog2(MAX_RETRY + 2);

    localparam logic [ADDR_W-1:0] BEAT_MASK =
        ~((ADDR_W'(1) << BYTE_W) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << (BYTE_W + LINE_BEATS_W)) - ADDR_W'(1));
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(BEATS);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_unc_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_q;
    logic [RW-1:0]     r_retry;

    logic                    w_accept;
    logic                    w_ar_fire;
    logic                    w_r_fire;
    logic                    w_can_retry;
    logic [CNT_W-1:0]        w_len;
    logic                    w_cnt_eq;
    logic                    w_cnt_le;
    logic                    w_beat_err;
    logic [LINE_BEATS_W-1:0] w_start;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_ar_fire   = (r_state == S_ADDR) && axi.arready;
    assign w_r_fire    = (r_state == S_DATA) && axi.rvalid;
    assign w_can_retry = r_retry < RETRY_MAX;

    assign w_len    = r_unc_q ? '0 : CNT_W'(BEATS - 1);
    assign w_cnt_eq = r_cnt == w_len;
    assign w_cnt_le = r_cnt <= w_len;

    // Bad response, early rlast, or missing rlast on the final expected beat.
    assign w_beat_err = (axi.rresp != RESP_OKAY)
                      || (axi.rlast && !w_cnt_eq)
                      || (!axi.rlast && w_cnt_eq);

    assign w_start = (r_unc_q || WRAP_EN)
                   ? r_addr_q[BYTE_W +: LINE_BEATS_W] : '0;

    assign axi.arvalid = r_state == S_ADDR;
    assign axi.rready  = r_state == S_DATA;
    assign axi.arlen   = r_unc_q ? 8'd0 : 8'(BEATS - 1);
    assign axi.arsize  = 3'(BYTE_W);
    assign axi.arburst = (!r_unc_q && WRAP_EN) ? BURST_WRAP : BURST_INCR;
    assign axi.araddr  = (r_unc_q || WRAP_EN)
                       ? (r_addr_q & BEAT_MASK) : (r_addr_q & LINE_MASK);
    assign axi.arlock  = 1'b0;
    assign axi.arcache = AR_CACHE;
    assign axi.arprot  = AR_PROT;
    assign axi.arqos   = AR_QOS;
    assign axi.arid    = AXI_ID_W'(AXI_ID);

    assign req_ready  = r_state == S_IDLE;
    assign busy       = r_state != S_IDLE;
    assign beat_data  = axi.rdata;
    assign beat_idx   = w_start + r_cnt[LINE_BEATS_W-1:0];
    assign beat_valid = w_r_fire && (axi.rresp == RESP_OKAY)
                      && !r_err_q && w_cnt_le;
    assign beat_last  = beat_valid && axi.rlast && w_cnt_eq;
    assign done       = (r_state == S_RESP) && !r_err_q;
    assign error      = (r_state == S_RESP) && r_err_q && !w_can_retry;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_ADDR;
            S_ADDR: if (axi.arready) w_next = S_DATA;
            S_DATA: if (axi.rvalid && axi.rlast) w_next = S_RESP;
            S_RESP: w_next = (r_err_q && w_can_retry) ? S_ADDR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_addr_q <= '0;
            r_unc_q  <= 1'b0;
            r_cnt    <= '0;
            r_err_q  <= 1'b0;
            r_retry  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr_q <= req_addr;
                r_unc_q  <= req_uncached;
                r_retry  <= '0;
            end
            if (w_ar_fire) begin
                r_cnt   <= '0;
                r_err_q <= 1'b0;
            end else if (w_r_fire) begin
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
                if (w_beat_err) r_err_q <= 1'b1;
            end
            if ((r_state == S_RESP) && r_err_q && w_can_retry)
                r_retry <= r_retry + 1'b1;
        end
    end

endmodule

// File: tb/tb_refill_read_channel.sv
// Directed bench: three DUT variants (WRAP, INCR, MAX_RETRY=1) on one R stream.
module tb_refill_read_channel;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  rv;
    logic [31:0] req_addr;
    logic        unc;
    logic        arready, rvalid, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          sel;
    int          vec = 0;
    int          mis = 0;
    int          ar_issues = 0;

    logic [2:0]  rr_a, busy_a, bv_a, bl_a, done_a, err_a, arv_a, rrd_a;
    logic [1:0]  bidx_a [3];
    logic [31:0] bdat_a [3];
    logic [31:0] arad_a [3];
    logic [7:0]  arln_a [3];
    logic [2:0]  arsz_a [3];
    logic [1:0]  arbu_a [3];
    logic [3:0]  arca_a [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen
        refill_read_channel_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(4)) bus ();
        assign bus.arready = arready && (sel == g);
        assign bus.rvalid  = rvalid && (sel == g);
        assign bus.rdata   = rdata;
        assign bus.rresp   = rresp;
        assign bus.rlast   = rlast;
        refill_read_channel #(
            .WRAP_EN   ((g == 1) ? 1'b0 : 1'b1),
            .MAX_RETRY ((g == 2) ? 1 : 3)
        ) dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .req_valid    (rv[g]),
            .req_ready    (rr_a[g]),
            .req_addr     (req_addr),
            .req_uncached (unc),
            .busy         (busy_a[g]),
            .beat_valid   (bv_a[g]),
            .beat_idx     (bidx_a[g]),
            .beat_data    (bdat_a[g]),
            .beat_last    (bl_a[g]),
            .done         (done_a[g]),
            .error        (err_a[g]),
            .axi          (bus.master)
        );
        assign arv_a[g]  = bus.arvalid;
        assign rrd_a[g]  = bus.rready;
        assign arad_a[g] = bus.araddr;
        assign arln_a[g] = bus.arlen;
        assign arsz_a[g] = bus.arsize;
        assign arbu_a[g] = bus.arburst;
        assign arca_a[g] = bus.arcache;
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(string tag);
        chk({tag, "_req_ready"}, 64'(rr_a[sel]), 1);
        chk({tag, "_busy"}, 64'(busy_a[sel]), 0);
        chk({tag, "_arvalid"}, 64'(arv_a[sel]), 0);
        chk({tag, "_rready"}, 64'(rrd_a[sel]), 0);
        chk({tag, "_done"}, 64'(done_a[sel]), 0);
        chk({tag, "_error"}, 64'(err_a[sel]), 0);
    endtask

    task automatic do_req(int s, logic [31:0] a, logic u);
        sel = s;
        rv[s] = 1'b1;
        req_addr = a;
        unc = u;
        step();
        rv = '0;
    endtask

    task automatic do_ar(logic [31:0] a, logic [7:0] len, logic [1:0] bu);
        chk("arvalid", 64'(arv_a[sel]), 1);
        chk("busy", 64'(busy_a[sel]), 1);
        chk("req_ready_busy", 64'(rr_a[sel]), 0);
        chk("araddr", 64'(arad_a[sel]), 64'(a));
        chk("arlen", 64'(arln_a[sel]), 64'(len));
        chk("arburst", 64'(arbu_a[sel]), 64'(bu));
        chk("arsize", 64'(arsz_a[sel]), 2);
        chk("arcache", 64'(arca_a[sel]), 3);
        if (arv_a[sel]) ar_issues++;
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("rready", 64'(rrd_a[sel]), 1);
        chk("arvalid_drop", 64'(arv_a[sel]), 0);
    endtask

    task automatic beat(logic [31:0] d, logic [1:0] rs, logic l,
                        logic ev, logic [1:0] ei, logic el);
        rvalid = 1'b1;
        rdata = d;
        rresp = rs;
        rlast = l;
        #1;
        chk("beat_valid", 64'(bv_a[sel]), 64'(ev));
        chk("beat_last", 64'(bl_a[sel]), 64'(el));
        if (ev) begin
            chk("beat_idx", 64'(bidx_a[sel]), 64'(ei));
            chk("beat_data", 64'(bdat_a[sel]), 64'(d));
        end
        step();
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
    endtask

    task automatic resp(logic ed, logic ee);
        chk("done", 64'(done_a[sel]), 64'(ed));
        chk("error", 64'(err_a[sel]), 64'(ee));
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        rv = '0;
        req_addr = '0;
        unc = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rdata = '0;
        rresp = '0;
        sel = 0;
        step();
        step();
        idle_chk("rst");
        reset_n = 1'b1;
        step();
        idle_chk("post_rst");

        // critical-word-first WRAP refill
        do_req(0, 32'h1008, 1'b0);
        do_ar(32'h1008, 8'd3, 2'b10);
        beat(32'hA0, 2'b00, 1'b0, 1'b1, 2'd2, 1'b0);
        beat(32'hA1, 2'b00, 1'b0, 1'b1, 2'd3, 1'b0);
        beat(32'hA2, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0);
        beat(32'hA3, 2'b00, 1'b1, 1'b1, 2'd1, 1'b1);
        resp(1'b1, 1'b0);
        idle_chk("wrap_end");

        // line-aligned INCR refill
        do_req(1, 32'h100C, 1'b0);
        do_ar(32'h1000, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++)
            beat(32'hB0 + 32'(i), 2'b00, i == 3, 1'b1, 2'(i), i == 3);
        resp(1'b1, 1'b0);
        idle_chk("incr_end");

        // uncached single beat
        do_req(0, 32'h2006, 1'b1);
        do_ar(32'h2004, 8'd0, 2'b01);
        beat(32'hC0FFEE, 2'b00, 1'b1, 1'b1, 2'd1, 1'b1);
        resp(1'b1, 1'b0);
        idle_chk("unc_end");

        // SLVERR on second beat, clean retry
        do_req(0, 32'h1008, 1'b0);
        do_ar(32'h1008, 8'd3, 2'b10);
        beat(32'hD0, 2'b00, 1'b0, 1'b1, 2'd2, 1'b0);
        beat(32'hD1, 2'b10, 1'b0, 1'b0, 2'd3, 1'b0);
        beat(32'hD2, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
        beat(32'hD3, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0);
        resp(1'b0, 1'b0);
        do_ar(32'h1008, 8'd3, 2'b10);
        beat(32'hE0, 2'b00, 1'b0, 1'b1, 2'd2, 1'b0);
        beat(32'hE1, 2'b00, 1'b0, 1'b1, 2'd3, 1'b0);
        beat(32'hE2, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0);
        beat(32'hE3, 2'b00, 1'b1, 1'b1, 2'd1, 1'b1);
        resp(1'b1, 1'b0);
        idle_chk("retry_end");

        // persistent SLVERR with MAX_RETRY=1
        ar_issues = 0;
        do_req(2, 32'h3000, 1'b0);
        for (int b = 0; b < 2; b++) begin
            do_ar(32'h3000, 8'd3, 2'b10);
            beat(32'hF0, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0);
            beat(32'hF1, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0);
            beat(32'hF2, 2'b00, 1'b0, 1'b0, 2'd2, 1'b0);
            beat(32'hF3, 2'b00, 1'b1, 1'b0, 2'd3, 1'b0);
            resp(1'b0, b == 1);
        end
        chk("ar_issues", 64'(ar_issues), 2);
        idle_chk("exhaust_end");

        // early rlast, then reset mid-DATA on the retry
        do_req(0, 32'h1000, 1'b0);
        do_ar(32'h1000, 8'd3, 2'b10);
        beat(32'h10, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0);
        beat(32'h11, 2'b00, 1'b0, 1'b1, 2'd1, 1'b0);
        beat(32'h12, 2'b00, 1'b1, 1'b1, 2'd2, 1'b0);
        resp(1'b0, 1'b0);
        do_ar(32'h1000, 8'd3, 2'b10);
        beat(32'h20, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0);
        rvalid = 1'b1;
        rdata = 32'h21;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_beat_valid", 64'(bv_a[sel]), 0);
        idle_chk("mid_rst");
        rvalid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        idle_chk("rst_release");

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
